// File: rtl/decode_stage.sv
// Registered valid/ready instruction-decode stage: opcode to ALU/register-file controls,
// with multi-cycle DIV stall, NOP bubble removal, illegal flagging, flush and retire count.
module decode_stage #(
    parameter int CMD_W      = 6,
    parameter int FUNC_W     = 4,
    parameter int FLAG_W     = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              write,
    output logic              src_addr_sel,
    output logic              des_addr_sel,
    output logic              pc_ctrl,
    output logic [2:0]        alu_bport_sel,
    output logic [FUNC_W-1:0] func,
    output logic              illegal,
    output logic              busy,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [CMD_W-1:0] OP_NOP  = CMD_W'(0);
    localparam logic [CMD_W-1:0] OP_ADD  = CMD_W'(1);
    localparam logic [CMD_W-1:0] OP_SUB  = CMD_W'(2);
    localparam logic [CMD_W-1:0] OP_MUL  = CMD_W'(3);
    localparam logic [CMD_W-1:0] OP_ADDI = CMD_W'(4);
    localparam logic [CMD_W-1:0] OP_LDI  = CMD_W'(5);
    localparam logic [CMD_W-1:0] OP_LW   = CMD_W'(6);
    localparam logic [CMD_W-1:0] OP_SW   = CMD_W'(7);
    localparam logic [CMD_W-1:0] OP_BEQ  = CMD_W'(8);
    localparam logic [CMD_W-1:0] OP_J    = CMD_W'(9);
    localparam logic [CMD_W-1:0] OP_BNE  = CMD_W'(10);
    localparam logic [CMD_W-1:0] OP_MOV  = CMD_W'(11);
    localparam logic [CMD_W-1:0] OP_DIV  = {CMD_W{1'b1}};

    localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_MUL = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_DIV = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] F_LDI = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_BNE = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_BEQ = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_MOV = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] F_NA  = {FUNC_W{1'b1}};

    localparam int DC_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic DIV_MULTI = (DIV_CYCLES > 1);

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_DIVW = 2'd2} state_t;

    typedef struct packed {
        logic              illegal;
        logic              write;
        logic              src;
        logic              des;
        logic              pc;
        logic [2:0]        bsel;
        logic [FUNC_W-1:0] func;
    } ctrl_t;

    // Branches are taken unless the flags report exactly 1 (equal / zero result).
    function automatic ctrl_t decode(input logic [CMD_W-1:0] c, input logic [FLAG_W-1:0] f);
        ctrl_t d;
        d      = '0;
        d.func = F_NA;
        case (c)
            OP_NOP:  d.func = F_NA;
            OP_ADD:  begin d.func = F_ADD; d.write = 1'b1; d.src = 1'b1; d.des = 1'b1; end
            OP_SUB:  begin d.func = F_SUB; d.write = 1'b1; d.src = 1'b1; d.des = 1'b1; end
            OP_MUL:  begin d.func = F_MUL; d.write = 1'b1; d.src = 1'b1; d.des = 1'b1; end
            OP_DIV:  begin d.func = F_DIV; d.write = 1'b1; d.src = 1'b1; d.des = 1'b1; end
            OP_ADDI: begin d.func = F_ADD; d.write = 1'b1; d.des = 1'b1; d.bsel = 3'd1; end
            OP_LDI:  begin d.func = F_LDI; d.write = 1'b1; d.bsel = 3'd1; end
            OP_LW:   begin d.func = F_LDI; d.write = 1'b1; d.bsel = 3'd2; end
            OP_SW:   begin d.func = F_LDI; d.write = 1'b1; end
            OP_MOV:  begin d.func = F_MOV; d.write = 1'b1; end
            OP_J:    d.pc = 1'b1;
            OP_BEQ:  begin d.func = F_BEQ; d.pc = (f != FLAG_W'(1)); end
            OP_BNE:  begin d.func = F_BNE; d.pc = (f != FLAG_W'(1)); end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    state_t           state_q;
    logic [DC_W-1:0]  div_cnt_q;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    logic [CNT_W-1:0] retired_q;
    logic             accept_s;

    assign ctrl_d   = decode(cmd, alu_flags);
    assign in_ready = !rst && !flush &&
                      ((state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready));
    assign accept_s = in_valid && in_ready;

    // Stage FSM, DIV countdown, output control registers and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            div_cnt_q    <= '0;
            ctrl_q       <= '0;
            ctrl_q.func  <= F_NA;
            retired_q    <= '0;
        end else begin
            if ((state_q == S_FULL) && out_ready) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (flush) begin
                state_q   <= S_EMPTY;
                div_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_EMPTY, S_FULL: begin
                        if (accept_s && (cmd != OP_NOP)) begin
                            ctrl_q <= ctrl_d;
                            if ((cmd == OP_DIV) && DIV_MULTI) begin
                                state_q   <= S_DIVW;
                                div_cnt_q <= DC_W'(DIV_CYCLES - 1);
                            end else begin
                                state_q <= S_FULL;
                            end
                        end else if ((state_q == S_FULL) && !out_ready) begin
                            state_q <= S_FULL;
                        end else begin
                            state_q <= S_EMPTY;
                        end
                    end
                    S_DIVW: begin
                        if (div_cnt_q == DC_W'(1)) begin
                            state_q   <= S_FULL;
                            div_cnt_q <= '0;
                        end else begin
                            div_cnt_q <= div_cnt_q - DC_W'(1);
                        end
                    end
                    default: begin
                        state_q   <= S_EMPTY;
                        div_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign out_valid     = (state_q == S_FULL);
    assign busy          = (state_q == S_DIVW);
    assign write         = ctrl_q.write;
    assign src_addr_sel  = ctrl_q.src;
    assign des_addr_sel  = ctrl_q.des;
    assign pc_ctrl       = ctrl_q.pc;
    assign alu_bport_sel = ctrl_q.bsel;
    assign func          = ctrl_q.func;
    assign illegal       = ctrl_q.illegal;
    assign retired       = retired_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed control vectors packed as
// {illegal, write, src, des, pc, bsel[2:0], func[3:0]}.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  cmd;
    logic [3:0]  alu_flags;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        write, src_addr_sel, des_addr_sel, pc_ctrl;
    logic [2:0]  alu_bport_sel;
    logic [3:0]  func;
    logic        illegal;
    logic        busy;
    logic [15:0] retired;
    logic [11:0] obs;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    decode_stage #(.CMD_W(6), .FUNC_W(4), .FLAG_W(4), .DIV_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cmd(cmd),
        .alu_flags(alu_flags), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .write(write), .src_addr_sel(src_addr_sel), .des_addr_sel(des_addr_sel),
        .pc_ctrl(pc_ctrl), .alu_bport_sel(alu_bport_sel), .func(func), .illegal(illegal),
        .busy(busy), .retired(retired)
    );

    assign obs = {illegal, write, src_addr_sel, des_addr_sel, pc_ctrl, alu_bport_sel, func};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; cmd = 6'd1; alu_flags = 4'd0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tests_run++;
        if ({out_valid, busy, retired, obs} !== {1'b0, 1'b0, 16'd0, 12'h00F}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ov=%b busy=%b ret=%0d ctrl=%h expected 0 0 0 00f", out_valid, busy, retired, obs);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  cmds [6] = '{6'd1, 6'd2, 6'd6, 6'd7, 6'd11, 6'd9};
        logic [11:0] exps [6] = '{12'h700, 12'h701, 12'h424, 12'h404, 12'h407, 12'h08F};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; cmd = cmds[i];
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick();
            tests_run++;
            if ({out_valid, obs} !== {1'b1, exps[i]}) begin
                tests_failed++;
                $display("FAIL b2b_beat[%0d]: got ov=%b ctrl=%h expected ov=1 ctrl=%h", i, out_valid, obs, exps[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if ({out_valid, retired} !== {1'b0, 16'd6}) begin
            tests_failed++;
            $display("FAIL b2b_retired: got ov=%b ret=%0d expected ov=0 ret=6", out_valid, retired);
        end
    endtask

    task automatic test_branch();
        in_valid = 1'b1; cmd = 6'd8; alu_flags = 4'd1;
        tick();
        tests_run++;
        if ({out_valid, obs} !== {1'b1, 12'h006}) begin
            tests_failed++; $display("FAIL beq_flags1: got ov=%b ctrl=%h expected ov=1 ctrl=006", out_valid, obs);
        end
        cmd = 6'd10; alu_flags = 4'd4;
        tick();
        tests_run++;
        if ({out_valid, obs} !== {1'b1, 12'h085}) begin
            tests_failed++; $display("FAIL bne_flags4: got ov=%b ctrl=%h expected ov=1 ctrl=085", out_valid, obs);
        end
        in_valid = 1'b0; alu_flags = 4'd0;
        tick();
        tests_run++;
        if (retired !== 16'd8) begin tests_failed++; $display("FAIL branch_retired: got %0d expected 8", retired); end
    endtask

    task automatic test_div();
        in_valid = 1'b1; cmd = 6'h3F; out_ready = 1'b1;
        tick();
        cmd = 6'd1;
        for (int i = 0; i < 7; i++) begin
            tests_run++;
            if ({busy, in_ready, out_valid} !== 3'b100) begin
                tests_failed++;
                $display("FAIL div_wait[%0d]: got busy=%b in_ready=%b ov=%b expected 1 0 0", i, busy, in_ready, out_valid);
            end
            tick();
        end
        tests_run++;
        if ({out_valid, busy, in_ready, obs} !== {1'b1, 1'b0, 1'b1, 12'h703}) begin
            tests_failed++;
            $display("FAIL div_beat: got ov=%b busy=%b in_ready=%b ctrl=%h expected 1 0 1 703", out_valid, busy, in_ready, obs);
        end
        tick();
        tests_run++;
        if ({out_valid, obs} !== {1'b1, 12'h700}) begin
            tests_failed++; $display("FAIL div_then_add: got ov=%b ctrl=%h expected ov=1 ctrl=700", out_valid, obs);
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (retired !== 16'd10) begin tests_failed++; $display("FAIL div_retired: got %0d expected 10", retired); end
    endtask

    task automatic test_nop_illegal();
        logic [5:0] cmds [4] = '{6'd0, 6'd1, 6'd0, 6'h20};
        logic       expv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; cmd = cmds[i];
            tick();
            tests_run++;
            if (out_valid !== expv[i]) begin
                tests_failed++; $display("FAIL nop_seq_valid[%0d]: got %b expected %b", i, out_valid, expv[i]);
            end
            if (i == 1) begin
                tests_run++;
                if (obs !== 12'h700) begin tests_failed++; $display("FAIL nop_seq_add: got %h expected 700", obs); end
            end else if (i == 3) begin
                tests_run++;
                if (obs !== 12'h80F) begin tests_failed++; $display("FAIL illegal_beat: got %h expected 80f", obs); end
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if ({out_valid, retired} !== {1'b0, 16'd12}) begin
            tests_failed++; $display("FAIL nop_retired: got ov=%b ret=%0d expected ov=0 ret=12", out_valid, retired);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; cmd = 6'd4;
        tick();
        cmd = 6'd11;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, 12'h510}) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got ov=%b in_ready=%b ctrl=%h expected 1 0 510", i, out_valid, in_ready, obs);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (retired !== 16'd12) begin tests_failed++; $display("FAIL stall_retired_hold: got %0d expected 12", retired); end
        tick();
        tests_run++;
        if ({out_valid, retired} !== {1'b0, 16'd13}) begin
            tests_failed++; $display("FAIL stall_release: got ov=%b ret=%0d expected ov=0 ret=13", out_valid, retired);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1; in_valid = 1'b1; cmd = 6'h3F;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1; in_valid = 1'b1; cmd = 6'd1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_divw_in_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if ({out_valid, busy} !== 2'b00) begin
            tests_failed++; $display("FAIL flush_divw: got ov=%b busy=%b expected 0 0", out_valid, busy);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            tests_run++;
            if ({out_valid, busy} !== 2'b00) begin
                tests_failed++; $display("FAIL flush_divw_quiet[%0d]: got ov=%b busy=%b expected 0 0", i, out_valid, busy);
            end
        end
        out_ready = 1'b0; in_valid = 1'b1; cmd = 6'd2;
        tick();
        flush = 1'b1; out_ready = 1'b1; cmd = 6'd1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_full_in_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if ({out_valid, retired} !== {1'b0, 16'd14}) begin
            tests_failed++; $display("FAIL flush_full: got ov=%b ret=%0d expected ov=0 ret=14", out_valid, retired);
        end
        in_valid = 1'b1; cmd = 6'd1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, obs} !== {1'b1, 12'h700}) begin
            tests_failed++; $display("FAIL post_flush_add: got ov=%b ctrl=%h expected ov=1 ctrl=700", out_valid, obs);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        out_ready = 1'b1; in_valid = 1'b1; cmd = 6'h3F;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_div_in_ready: got %b expected 0", in_ready); end
        tick();
        tests_run++;
        if ({out_valid, busy, retired, obs} !== {1'b0, 1'b0, 16'd0, 12'h00F}) begin
            tests_failed++;
            $display("FAIL rst_div_outputs: got ov=%b busy=%b ret=%0d ctrl=%h expected 0 0 0 00f", out_valid, busy, retired, obs);
        end
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            tests_run++;
            if ({out_valid, busy} !== 2'b00) begin
                tests_failed++; $display("FAIL rst_div_quiet[%0d]: got ov=%b busy=%b expected 0 0", i, out_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_branch();
        test_div();
        test_nop_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode stage for the CPU datapath, sitting between instruction fetch and the ALU/register-file control inputs. It is the pipelined successor of the combinational opcode decoder, with parametrised widths and a valid/ready interface on both sides. It adds a multi-cycle DIV stall counter, NOP bubble removal, illegal-opcode flagging, a synchronous flush for branch redirect, and a retired-instruction counter.

## Interface
- CMD_W, 6, opcode width; must be ≥ 4.
- FUNC_W, 4, ALU func width; must be ≥ 4.
- FLAG_W, 4, ALU flag width.
- DIV_CYCLES, 8, cycles from DIV acceptance to DIV output beat; must be ≥ 1.
- CNT_W, 16, width of the retired-instruction counter.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  cmd/alu_flags valid.
- in_ready  out  1  stage can accept; combinational.
- cmd  in  CMD_W  opcode.
- alu_flags  in  FLAG_W  ALU flags sampled with cmd, used for branches.
- flush  in  1  synchronous squash of all in-flight state.
- out_valid  out  1  decoded control beat valid.
- out_ready  in  1  downstream accepts the beat.
- write, src_addr_sel, des_addr_sel, pc_ctrl  out  1 each  decoded controls.
- alu_bport_sel  out  3  ALU B-port mux select.
- func  out  FUNC_W  ALU function.
- illegal  out  1  beat carries an unrecognised opcode.
- busy  out  1  a DIV is counting.
- retired  out  CNT_W  count of output handshakes.

## Operation
- Opcodes (zero-extended to CMD_W): NOP 0, ADD 1, SUB 2, MUL 3, ADDI 4, LDI 5, LW 6, SW 7, BEQ 8, J 9, BNE 10, MOV 11. DIV is all-ones of CMD_W.
- Func codes (zero-extended): ADD 0, SUB 1, MUL 2, DIV 3, LDI 4, BNE 5, BEQ 6, MOV 7. NA is all-ones of FUNC_W.
- func mapping:
  - ADD and ADDI → ADD; SUB → SUB; MUL → MUL; DIV → DIV; BNE → BNE; BEQ → BEQ; MOV → MOV.
  - LDI, LW and SW → LDI.
  - Everything else, including J, → NA.
- write = 1 for ADD, SUB, MUL, DIV, ADDI, LDI, LW, SW, MOV.
- alu_bport_sel = 1 for LDI and ADDI, 2 for LW, otherwise 0.
- src_addr_sel = 1 for ADD, SUB, MUL, DIV.
- des_addr_sel = 1 for ADD, SUB, MUL, DIV, ADDI.
- pc_ctrl:
  - J → 1.
  - BEQ/BNE → 0 if alu_flags == 1, else 1.
  - Otherwise 0.
- Illegal opcode (not in the map): beat is emitted with func = NA, all other controls 0, illegal = 1.
- NOP is accepted and consumed with no output beat (bubble removal).
- FSM states:
  - EMPTY: no beat held.
    - Accept non-NOP, non-DIV → FULL.
    - Accept DIV with DIV_CYCLES > 1 → DIVW, counter loaded with DIV_CYCLES-1.
    - Accept DIV with DIV_CYCLES == 1 → FULL.
  - FULL: out_valid = 1.
    - out_ready with a simultaneous accept → state taken from the new instruction, as from EMPTY.
    - out_ready without an accept → EMPTY.
    - No out_ready → hold.
  - DIVW: busy = 1, in_ready = 0, counter decrements each cycle; reaching 1 → FULL on the next edge.
- in_ready = !rst & !flush & (EMPTY | (FULL & out_ready)).
- flush has priority over everything:
  - Next state is EMPTY, out_valid = 0 next cycle, counter cleared.
  - The input in that cycle is not accepted.
  - A beat handshaking in the same cycle as flush still counts in retired.
- Output registers load only on acceptance; they stay stable while out_valid & !out_ready.
- retired increments on each out_valid & out_ready and wraps modulo 2^CNT_W. It is not cleared by flush.

## Timing
- Reset values:
  - out_valid = 0, busy = 0, illegal = 0, retired = 0.
  - write = 0, src_addr_sel = 0, des_addr_sel = 0, pc_ctrl = 0, alu_bport_sel = 0.
  - func = NA; state = EMPTY.
- in_ready = 0 during every cycle rst is high.
- Non-DIV latency: accepted at edge N → out_valid high after edge N.
- Throughput is 1 beat/cycle with out_ready held high.
- DIV latency: accepted at edge N → out_valid high after edge N+DIV_CYCLES-1. in_ready stays low until the DIV beat handshakes.
- Reset mid-DIV: FSM returns to EMPTY and the counter clears; no DIV beat is emitted.
- Backpressure: controls are held unchanged for any number of stalled cycles.

## Test plan
- Back-to-back ADD, SUB, LW, SW, MOV, J with out_ready=1 → one beat per cycle, 1-cycle latency:
  - ADD gives func=0, write=1, src=1, des=1, bsel=0.
  - LW gives func=4, bsel=2.
  - J gives pc_ctrl=1, func=15.
  - retired = 6.
- BEQ with alu_flags=1 → pc_ctrl=0. BNE with alu_flags=4 → pc_ctrl=1, func=5.
- DIV (cmd=6'h3F) with DIV_CYCLES=8 → busy high for 7 cycles, in_ready low, then a beat with func=3, write=1. A following ADD is accepted only after the DIV handshake.
- NOP, ADD, NOP, cmd=6'h20 → exactly 2 beats: ADD, then illegal=1 with func=15 and write=0.
- out_ready low for 5 cycles with ADDI held → controls stable, in_ready=0. Release → one beat and retired +1.
- flush during DIVW and, separately, in FULL → out_valid=0 next cycle, busy=0, input not accepted that cycle. rst asserted mid-DIV → all outputs at reset values.
